// File: rtl/updown_sequence_checker_pkg.sv
// Shared definitions for the up/down counter sequence checker and its companion benches.
package updown_sequence_checker_pkg;

  typedef enum logic [1:0] {
    UNSYNC  = 2'd0,
    SYNCING = 2'd1,
    LOCKED  = 2'd2
  } chk_state_t;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

endpackage

// File: rtl/updown_sequence_checker_if.sv
// Sample/status bundle between an up/down counter environment and the sequence checker.
interface updown_sequence_checker_if #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned ERR_W = 8
);
  logic             sample_en;
  logic             mode;
  logic [WIDTH-1:0] q_in;
  logic             err_clr;
  logic             locked;
  logic             step_ok;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [WIDTH-1:0] expected;

  modport master (
    output sample_en, mode, q_in, err_clr,
    input  locked, step_ok, err_pulse, err_count, expected
  );

  modport slave (
    input  sample_en, mode, q_in, err_clr,
    output locked, step_ok, err_pulse, err_count, expected
  );
endinterface

// File: rtl/updown_sequence_checker_next.sv
// Combinational next-count prediction: +1 for up, -1 for down, wrapping modulo 2^WIDTH.
module updown_next_value
  import updown_sequence_checker_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] prev,
  input  logic             mode,
  output logic [WIDTH-1:0] pred
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_comb begin
    pred = (mode == MODE_DOWN) ? prev - ONE : prev + ONE;
  end
endmodule

// File: rtl/updown_sequence_checker.sv
// Monitors an up/down counter's Q bus, locks after LOCK_COUNT correct steps and tallies step errors.
module updown_sequence_checker
  import updown_sequence_checker_pkg::*;
#(
  parameter int unsigned WIDTH      = 3,
  parameter int unsigned LOCK_COUNT = 2,
  parameter int unsigned ERR_W      = 8
) (
  input  logic                      clk,
  input  logic                      clr,
  updown_sequence_checker_if.slave  bus
);
  localparam int unsigned      CNT_W    = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LOCK_TGT = CNT_W'(LOCK_COUNT);
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

  chk_state_t       state;
  logic [WIDTH-1:0] prev;
  logic [CNT_W-1:0] match_cnt;
  logic [WIDTH-1:0] step_pred;
  logic [WIDTH-1:0] next_pred;
  logic             match;

  // Check the current sample against the previous one, and predict the following sample.
  updown_next_value #(.WIDTH(WIDTH)) u_step_pred (
    .prev (prev),
    .mode (bus.mode),
    .pred (step_pred)
  );

  updown_next_value #(.WIDTH(WIDTH)) u_next_pred (
    .prev (bus.q_in),
    .mode (bus.mode),
    .pred (next_pred)
  );

  always_comb begin
    match = (bus.q_in == step_pred);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state         <= UNSYNC;
      prev          <= '0;
      match_cnt     <= '0;
      bus.expected  <= '0;
      bus.err_count <= '0;
      bus.locked    <= 1'b0;
      bus.step_ok   <= 1'b0;
      bus.err_pulse <= 1'b0;
    end else begin
      bus.step_ok   <= 1'b0;
      bus.err_pulse <= 1'b0;
      if (bus.sample_en) begin
        prev         <= bus.q_in;
        bus.expected <= next_pred;
        unique case (state)
          UNSYNC: begin
            state     <= SYNCING;
            match_cnt <= '0;
          end
          SYNCING: begin
            if (!match) begin
              match_cnt <= '0;
            end else if (match_cnt + CNT_ONE == LOCK_TGT) begin
              state      <= LOCKED;
              bus.locked <= 1'b1;
              match_cnt  <= '0;
            end else begin
              match_cnt <= match_cnt + CNT_ONE;
            end
          end
          LOCKED: begin
            if (match) begin
              bus.step_ok <= 1'b1;
            end else begin
              bus.err_pulse <= 1'b1;
              state         <= SYNCING;
              bus.locked    <= 1'b0;
              match_cnt     <= '0;
              if (bus.err_count != '1) bus.err_count <= bus.err_count + ERR_ONE;
            end
          end
          default: begin
            state      <= UNSYNC;
            bus.locked <= 1'b0;
            match_cnt  <= '0;
          end
        endcase
      end
      // Last assignment wins, so a clear overrides a same-cycle increment.
      if (bus.err_clr) bus.err_count <= '0;
    end
  end
endmodule
